// File: rtl/seq_shifter32_pkg.sv
// Shared constants and state encoding for the multi-cycle shifter.
package seq_shifter32_pkg;
  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic [1:0] ALUC_SRA = 2'b00;
  localparam logic [1:0] ALUC_SRL = 2'b10;
  localparam logic [1:0] ALUC_SLL = 2'b01;  // 2'b11 decodes as SLL too

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/seq_shifter32_step.sv
// Single-position shift selected by the ALU operation code.
module shift_step32
  import seq_shifter32_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] d,
  input  logic [1:0]   op,
  output logic [W-1:0] q
);
  always_comb begin
    q = {d[W-2:0], 1'b0};
    case (op)
      ALUC_SRA: q = {d[W-1], d[W-1:1]};
      ALUC_SRL: q = {1'b0, d[W-1:1]};
      default:  q = {d[W-2:0], 1'b0};
    endcase
  end
endmodule

// File: rtl/seq_shifter32.sv
// Bit-serial shifter: one position per clock, valid/ready on both sides.
module seq_shifter32
  import seq_shifter32_pkg::*;
#(
  parameter int WIDTH   = seq_shifter32_pkg::WIDTH,
  parameter int SHAMT_W = seq_shifter32_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] b,
  input  logic [1:0]         aluc,
  output logic [WIDTH-1:0]   c,
  output logic               out_valid,
  input  logic               out_ready
);
  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc, acc_nxt, step;
  logic [SHAMT_W-1:0] cnt, cnt_nxt;
  logic [1:0]         op, op_nxt;

  shift_step32 #(.W(WIDTH)) u_step (.d(acc), .op(op), .q(step));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      op    <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      op    <= op_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    op_nxt    = op;
    case (state)
      IDLE: begin
        if (in_valid) begin
          acc_nxt   = a;
          cnt_nxt   = b;
          op_nxt    = aluc;
          state_nxt = (b == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        acc_nxt = step;
        cnt_nxt = cnt - 1'b1;
        // cnt==1 means this edge performs the final shift
        if (cnt == SHAMT_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign c         = acc;
endmodule

// File: tb/tb_seq_shifter32.sv
// Directed + random scoreboard bench for seq_shifter32.
module tb_seq_shifter32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [4:0]  b = '0;
  logic [1:0]  aluc = '0;
  logic [31:0] c;
  logic        out_valid;
  logic        out_ready = 1'b1;

  seq_shifter32 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluc(aluc), .c(c), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] c;
    logic [4:0]  b;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  exp_t cur;
  int   checks = 0, passes = 0;
  int   cyc = 0;
  bit   busy = 0, inflight = 0, ir_chk = 0;
  int   stall_mode = 0;  // 0: always ready, 1: random stalls, 2: hold low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] s,
                                            input logic [1:0] op);
    case (op)
      2'b00:   return $unsigned($signed(x) >>> s);
      2'b10:   return x >> s;
      default: return x << s;
    endcase
  endfunction

  // Posedge bookkeeping: accepts, handshakes, reset flush.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete(); acc_q.delete();
      busy = 0; inflight = 0; ir_chk = 0;
    end else begin
      if (in_valid && in_ready) begin acc_q.push_back(cyc); inflight = 1; end
      if (out_valid && out_ready) begin busy = 0; inflight = 0; ir_chk = 1; end
    end
  end

  // Negedge monitor: compares outputs against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (ir_chk) begin
        chk("in_ready_after_consume", {31'b0, in_ready}, 32'd1);
        ir_chk = 0;
      end else if (inflight) begin
        chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
      end
      if (out_valid) begin
        if (!busy) begin
          if (exp_q.size() == 0 || acc_q.size() == 0) begin
            chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
            cur.c = c; cur.b = '0;
          end else begin
            cur = exp_q.pop_front();
            chk("latency", 32'(cyc - acc_q.pop_front() + 1), 32'(cur.b) + 32'd1);
          end
          busy = 1;
        end
        chk("result", c, cur.c);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    case (stall_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] ia, input logic [4:0] ib, input logic [1:0] op,
                       input logic [31:0] exp);
    int n = 0;
    exp_t e;
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) chk("issue_timeout", {31'b0, in_ready}, 32'd1);
    e.c = exp; e.b = ib;
    exp_q.push_back(e);
    in_valid = 1'b1; a = ia; b = ib; aluc = op;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || inflight) && n < 2000) begin @(negedge clk); n++; end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra;
    logic [4:0]  rb;
    logic [1:0]  rop;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_c", c, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'h8000_0000, 5'd4,  2'b00, 32'hF800_0000);
    issue(32'h8000_0000, 5'd31, 2'b10, 32'h0000_0001);
    issue(32'h8000_0000, 5'd31, 2'b00, 32'hFFFF_FFFF);
    issue(32'h0000_0001, 5'd0,  2'b01, 32'h0000_0001);
    issue(32'h0000_0001, 5'd31, 2'b11, 32'h8000_0000);
    drain();

    // Backpressure while garbage requests hammer in_valid.
    stall_mode = 2;
    issue(32'h1234_5678, 5'd8, 2'b01, 32'h3456_7800);
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; a = $urandom; b = 5'($urandom); aluc = 2'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    stall_mode = 0;
    drain();

    // Reset mid-shift discards the in-flight result.
    issue(32'hFFFF_FFFF, 5'd10, 2'b10, 32'h003F_FFFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_c", c, 32'h0);
    issue(32'h0000_0001, 5'd1, 2'b01, 32'h0000_0002);
    drain();

    stall_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = 5'($urandom); rop = 2'($urandom);
      issue(ra, rb, rop, ref_shift(ra, rb, rop));
    end
    drain();
    stall_mode = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
